size_down_src_arb: RTL and testbench
====================================

# size_down_src_arb

Two-source, frame-granular arbiter that shares one downscaler instance between two free-running pixel streams (e.g. two cameras). The block locks onto a source at its start-of-frame, forwards exactly one complete frame with that source's geometry, then re-arbitrates; pixels from the non-granted source are discarded. It sits directly upstream of the downscaler and drives its `tdata_i`/`tvalid_i`/`width_i`/`height_i`.

## Interface
- `DATA_WIDTH`, 16, pixel width of both sources and the output.
- `clk_i`  in  1  single clock for all logic.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `s0_tdata_i` / `s1_tdata_i`  in  DATA_WIDTH  source pixel.
- `s0_tvalid_i` / `s1_tvalid_i`  in  1  pixel valid; no backpressure exists.
- `s0_sof_i` / `s1_sof_i`  in  1  first pixel of frame; qualified by the matching tvalid.
- `s0_width_i` / `s1_width_i`  in  16  pixels per line.
- `s0_height_i` / `s1_height_i`  in  16  lines per frame.
- `tdata_o`  out  DATA_WIDTH  forwarded pixel.
- `tvalid_o`  out  1  forwarded pixel valid.
- `width_o` / `height_o`  out  16  geometry latched at grant; held stable for the whole frame.
- `sel_o`  out  1  granted source index.
- `sof_o` / `eof_o`  out  1  coincide with first and last forwarded pixel.
- `err_o`  out  1  one-cycle pulse: granted frame aborted.

## Operation
- States: IDLE, FWD.
- IDLE: a source is eligible in a cycle when `sN_tvalid_i & sN_sof_i` and its width and height are both nonzero. No eligible source: stay in IDLE. Otherwise grant, latch that source's width/height into `width_o`/`height_o`, set `sel_o`, forward the sof pixel, enter FWD.
- Both eligible in the same cycle: round-robin; grant the source not served last. `last` resets to 1, so source 0 wins the first tie.
- FWD: forward each granted-source valid pixel. Column counter 0..width-1; row counter increments on the column wrap. The pixel with col=width-1 and row=height-1 asserts `eof_o`, updates `last`, returns to IDLE.
- Width=1 and height=1: the sof pixel is also eof; the block never enters FWD.
- Non-granted source pixels are always dropped, including in IDLE when they are not sof.
- Granted source presents sof before eof: pulse `err_o`, restart counters on that pixel, stay in FWD. Relatch geometry from the current inputs. Forward the pixel with `sof_o`=1.
- Counter arithmetic: 16-bit; comparisons against latched width-1/height-1. Input geometry changes during FWD are ignored.

## Timing
- All outputs registered; latency exactly 1 cycle from input pixel to `tvalid_o`.
- Reset (asynchronous, any time including mid-frame): state=IDLE; all counters=0; `last`=1. Output reset values: `tdata_o`=0, `tvalid_o`=0, `width_o`=0, `height_o`=0, `sel_o`=0, `sof_o`=0, `eof_o`=0, `err_o`=0. The first frame after reset requires a fresh sof.
- Back-to-back frames: re-arbitration happens in the same cycle the IDLE state is entered. A sof on the cycle immediately after eof is granted with no gap.
- `tdata_o` updates only when `tvalid_o`=1; it otherwise holds its value.
- `sof_o`, `eof_o` and `err_o` are asserted only together with `tvalid_o`.

## Configuration
- `SRC_ARB_FIXED_PRIO_EN`:
  - Defined: ties in IDLE always grant source 0; `last` is not used.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset, then source 0 sends a 4×2 frame (sof on the first pixel) while source 1 is idle -> 8 output pixels 1 cycle late; `sof_o` on pixel 0, `eof_o` on pixel 7; `width_o`=4, `height_o`=2; `sel_o`=0.
- Both sources sof in the same cycle, 2×2 frames, repeated 3 times -> grants 0,1,0. With `SRC_ARB_FIXED_PRIO_EN` -> grants 0,0,0.
- During a source-0 frame, source 1 streams a full frame -> no source-1 pixel appears; output count = 4×2 = 8.
- Source 0 sof again after 3 of 8 pixels -> `err_o` pulse on that pixel with `sof_o`=1; next `eof_o` after 8 more pixels.
- Source 0 has width=0 and asserts sof -> no grant, `tvalid_o` stays 0. A source-1 sof in a later cycle is granted.
- Assert `rst_i` mid-frame at pixel 5 -> all outputs 0 in the same cycle. Non-sof pixels after release are dropped until the next sof.

Source files
------------

// File: rtl/size_down_src_arb_if.sv
// rtl/size_down_src_arb_if.sv - two source pixel streams in, one arbitrated stream out
interface size_down_src_arb_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] s0_tdata_i;
  logic                  s0_tvalid_i;
  logic                  s0_sof_i;
  logic [15:0]           s0_width_i;
  logic [15:0]           s0_height_i;
  logic [DATA_WIDTH-1:0] s1_tdata_i;
  logic                  s1_tvalid_i;
  logic                  s1_sof_i;
  logic [15:0]           s1_width_i;
  logic [15:0]           s1_height_i;
  logic [DATA_WIDTH-1:0] tdata_o;
  logic                  tvalid_o;
  logic [15:0]           width_o;
  logic [15:0]           height_o;
  logic                  sel_o;
  logic                  sof_o;
  logic                  eof_o;
  logic                  err_o;

  modport master (
    output s0_tdata_i, s0_tvalid_i, s0_sof_i, s0_width_i, s0_height_i,
    output s1_tdata_i, s1_tvalid_i, s1_sof_i, s1_width_i, s1_height_i,
    input  tdata_o, tvalid_o, width_o, height_o, sel_o, sof_o, eof_o, err_o
  );

  modport slave (
    input  s0_tdata_i, s0_tvalid_i, s0_sof_i, s0_width_i, s0_height_i,
    input  s1_tdata_i, s1_tvalid_i, s1_sof_i, s1_width_i, s1_height_i,
    output tdata_o, tvalid_o, width_o, height_o, sel_o, sof_o, eof_o, err_o
  );
endinterface

// File: rtl/size_down_src_arb.sv
// rtl/size_down_src_arb.sv - frame-granular two-source arbiter in front of a downscaler
// SRC_ARB_FIXED_PRIO_EN: when defined, ties always go to source 0 instead of round-robin.
module size_down_src_arb #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  size_down_src_arb_if.slave   bus
);

  typedef enum logic {IDLE, FWD} state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic [15:0]           col_q, col_d;
  logic [15:0]           row_q, row_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic [15:0]           width_q, width_d;
  logic [15:0]           height_q, height_d;
  logic                  sel_q, sel_d;
  logic                  sof_q, sof_d;
  logic                  eof_q, eof_d;
  logic                  err_q, err_d;

  logic                  elig0, elig1, grant;
  logic                  g_valid, g_sof;
  logic [DATA_WIDTH-1:0] g_data;
  logic [15:0]           g_width, g_height;
  logic                  take, last_col;
  logic [15:0]           pos_col, pos_row, lim_w, lim_h;

  always_comb begin
    elig0 = bus.s0_tvalid_i & bus.s0_sof_i & (|bus.s0_width_i) & (|bus.s0_height_i);
    elig1 = bus.s1_tvalid_i & bus.s1_sof_i & (|bus.s1_width_i) & (|bus.s1_height_i);
`ifdef SRC_ARB_FIXED_PRIO_EN
    grant = elig1 & ~elig0;
`else
    grant = (elig0 & elig1) ? ~last_q : elig1;
`endif
  end

  always_comb begin
    g_valid  = sel_q ? bus.s1_tvalid_i : bus.s0_tvalid_i;
    g_sof    = sel_q ? bus.s1_sof_i    : bus.s0_sof_i;
    g_data   = sel_q ? bus.s1_tdata_i  : bus.s0_tdata_i;
    g_width  = sel_q ? bus.s1_width_i  : bus.s0_width_i;
    g_height = sel_q ? bus.s1_height_i : bus.s0_height_i;
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    col_d    = col_q;
    row_d    = row_q;
    tdata_d  = tdata_q;
    tvalid_d = 1'b0;
    width_d  = width_q;
    height_d = height_q;
    sel_d    = sel_q;
    sof_d    = 1'b0;
    eof_d    = 1'b0;
    err_d    = 1'b0;
    take     = 1'b0;
    last_col = 1'b0;
    pos_col  = '0;
    pos_row  = '0;
    lim_w    = width_q;
    lim_h    = height_q;

    case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          take     = 1'b1;
          sof_d    = 1'b1;
          sel_d    = grant;
          tdata_d  = grant ? bus.s1_tdata_i  : bus.s0_tdata_i;
          width_d  = grant ? bus.s1_width_i  : bus.s0_width_i;
          height_d = grant ? bus.s1_height_i : bus.s0_height_i;
          lim_w    = width_d;
          lim_h    = height_d;
        end
      end
      FWD: begin
        if (g_valid) begin
          take    = 1'b1;
          tdata_d = g_data;
          pos_col = col_q;
          pos_row = row_q;
          // A premature sof aborts the frame and restarts it on this very pixel.
          if (g_sof) begin
            err_d    = 1'b1;
            sof_d    = 1'b1;
            width_d  = g_width;
            height_d = g_height;
            lim_w    = g_width;
            lim_h    = g_height;
            pos_col  = '0;
            pos_row  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      tvalid_d = 1'b1;
      last_col = (pos_col == lim_w - 16'd1);
      if (last_col && (pos_row == lim_h - 16'd1)) begin
        eof_d   = 1'b1;
        last_d  = sel_d;
        state_d = IDLE;
        col_d   = '0;
        row_d   = '0;
      end else begin
        state_d = FWD;
        col_d   = last_col ? 16'd0 : pos_col + 16'd1;
        row_d   = last_col ? pos_row + 16'd1 : pos_row;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      col_q    <= '0;
      row_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      width_q  <= '0;
      height_q <= '0;
      sel_q    <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      col_q    <= col_d;
      row_q    <= row_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      width_q  <= width_d;
      height_q <= height_d;
      sel_q    <= sel_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      err_q    <= err_d;
    end
  end

  assign bus.tdata_o  = tdata_q;
  assign bus.tvalid_o = tvalid_q;
  assign bus.width_o  = width_q;
  assign bus.height_o = height_q;
  assign bus.sel_o    = sel_q;
  assign bus.sof_o    = sof_q;
  assign bus.eof_o    = eof_q;
  assign bus.err_o    = err_q;

endmodule

// File: tb/tb_size_down_src_arb.sv
// tb/tb_size_down_src_arb.sv - scoreboard bench for size_down_src_arb with a frame-level model
module tb_size_down_src_arb;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        eof;
    logic        err;
    logic        sel;
    logic [15:0] w;
    logic [15:0] h;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  size_down_src_arb_if #(.DATA_WIDTH(16)) bus ();

  size_down_src_arb #(.DATA_WIDTH(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  logic [15:0] d[2];
  logic        v[2];
  logic        s[2];
  logic [15:0] w[2];
  logic [15:0] h[2];

  // Frame-level model: which source owns the frame and how many pixels it has sent.
  bit m_busy;
  int m_sel, m_w, m_h, m_k, m_last;

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_w = 0; m_h = 0; m_k = 0; m_last = 1;
  endtask

  task automatic model_emit(input exp_t e_in);
    exp_t e;
    e = e_in;
    e.eof = (m_k == m_w * m_h - 1);
    if (e.eof) begin
      m_busy = 0;
      m_last = m_sel;
    end else begin
      m_busy = 1;
      m_k++;
    end
    exp_q.push_back(e);
  endtask

  task automatic model_step();
    exp_t e;
    bit   e0, e1;
    int   g;
    e = '0;
    if (!m_busy) begin
      e0 = v[0] && s[0] && (w[0] != 0) && (h[0] != 0);
      e1 = v[1] && s[1] && (w[1] != 0) && (h[1] != 0);
      if (e0 || e1) begin
`ifdef SRC_ARB_FIXED_PRIO_EN
        g = e0 ? 0 : 1;
`else
        if (e0 && e1) g = (m_last == 1) ? 0 : 1;
        else          g = e0 ? 0 : 1;
`endif
        m_sel = g; m_w = int'(w[g]); m_h = int'(h[g]); m_k = 0;
        e.data = d[g]; e.sof = 1'b1; e.sel = g[0];
        e.w = w[g]; e.h = h[g];
        model_emit(e);
      end
    end else if (v[m_sel]) begin
      if (s[m_sel]) begin
        m_w = int'(w[m_sel]); m_h = int'(h[m_sel]); m_k = 0;
        e.sof = 1'b1; e.err = 1'b1;
      end
      e.data = d[m_sel]; e.sel = m_sel[0];
      e.w = 16'(m_w); e.h = 16'(m_h);
      model_emit(e);
    end
  endtask

  task automatic apply();
    bus.s0_tdata_i = d[0]; bus.s0_tvalid_i = v[0]; bus.s0_sof_i = s[0];
    bus.s0_width_i = w[0]; bus.s0_height_i = h[0];
    bus.s1_tdata_i = d[1]; bus.s1_tvalid_i = v[1]; bus.s1_sof_i = s[1];
    bus.s1_width_i = w[1]; bus.s1_height_i = h[1];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    apply();
    model_step();
  endtask

  task automatic quiet();
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; s[i] = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    quiet();
    apply();
    rst = 1'b1;
    #1;
    chk("rst_tdata",  32'(bus.tdata_o),  0);
    chk("rst_tvalid", 32'(bus.tvalid_o), 0);
    chk("rst_geom",   {bus.width_o, bus.height_o}, 0);
    chk("rst_flags",  32'({bus.sel_o, bus.sof_o, bus.eof_o, bus.err_o}), 0);
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: pops one expectation per forwarded pixel; idle cycles must hold tdata and clear flags.
  logic [15:0] prev_data;
  always @(negedge clk) begin
    exp_t e, a;
    if (rst) begin
      prev_data = '0;
    end else if (bus.tvalid_o) begin
      a = '{data: bus.tdata_o, sof: bus.sof_o, eof: bus.eof_o, err: bus.err_o,
            sel: bus.sel_o, w: bus.width_o, h: bus.height_o};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pixel actual=%h required=none", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL pixel actual=%h required=%h (data,sof,eof,err,sel,w,h)", a, e);
        end
      end
      prev_data = bus.tdata_o;
    end else begin
      total++;
      if (bus.tdata_o !== prev_data || bus.sof_o || bus.eof_o || bus.err_o) begin
        bad++;
        $display("FAIL idle_hold actual=%h/%b%b%b required=%h/000", bus.tdata_o,
                 bus.sof_o, bus.eof_o, bus.err_o, prev_data);
      end
    end
  end

  task automatic send0(input int n, input int sof_at1, input int sof_at2, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      quiet();
      v[0] = 1'b1; s[0] = (i == sof_at1) || (i == sof_at2); d[0] = base + 16'(i);
      tick();
    end
  endtask

  initial begin
    quiet();
    for (int i = 0; i < 2; i++) begin
      d[i] = '0; w[i] = '0; h[i] = '0;
    end
    apply();
    model_reset();
    do_reset();

    // Single 4x2 frame from source 0.
    w[0] = 16'd4; h[0] = 16'd2;
    send0(8, 0, -1, 16'h0100);
    quiet(); tick(); tick();

    // Simultaneous sof on both sources, three times.
    w[0] = 16'd2; h[0] = 16'd2; w[1] = 16'd2; h[1] = 16'd2;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) begin
        v[0] = 1'b1; v[1] = 1'b1; s[0] = (i == 0); s[1] = (i == 0);
        d[0] = 16'h0200 + 16'(f * 16 + i); d[1] = 16'h8200 + 16'(f * 16 + i);
        tick();
      end
    end
    quiet(); tick();

    // Source 1 streams a whole frame while source 0 owns the output.
    w[0] = 16'd4; h[0] = 16'd2; w[1] = 16'd3; h[1] = 16'd2;
    for (int i = 0; i < 8; i++) begin
      v[0] = 1'b1; s[0] = (i == 0); d[0] = 16'h0300 + 16'(i);
      v[1] = (i >= 1 && i <= 6); s[1] = (i == 1); d[1] = 16'h8300 + 16'(i);
      tick();
    end
    quiet(); tick();

    // Premature sof after 3 pixels, then a full restarted frame.
    send0(11, 0, 3, 16'h0400);
    quiet(); tick();

    // Zero width is never granted; a later source-1 1x1 frame is.
    w[0] = 16'd0; h[0] = 16'd2;
    quiet(); v[0] = 1'b1; s[0] = 1'b1; d[0] = 16'h0500; tick();
    quiet(); tick();
    w[1] = 16'd1; h[1] = 16'd1;
    quiet(); v[1] = 1'b1; s[1] = 1'b1; d[1] = 16'h8500; tick();
    quiet(); tick(); tick();

    // Reset mid-frame, then non-sof pixels must be dropped until a fresh sof.
    w[0] = 16'd4; h[0] = 16'd2;
    send0(5, 0, -1, 16'h0600);
    do_reset();
    send0(3, -1, -1, 16'h0700);
    send0(8, 0, -1, 16'h0800);
    quiet(); tick();

    // Randomised traffic on both sources.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        v[i] = ($urandom_range(0, 9) < 7);
        s[i] = v[i] && ($urandom_range(0, 7) == 0);
        d[i] = 16'($urandom);
        if (s[i] || $urandom_range(0, 15) == 0) begin
          w[i] = 16'($urandom_range(0, 4));
          h[i] = 16'($urandom_range(0, 3));
        end
      end
      tick();
    end
    quiet(); tick(); tick(); tick();
    @(negedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
